// File: rtl/deadlock_idx0_monitor.sv
// rtl/deadlock_idx0_monitor.sv - deadlock detector for a 5-process dataflow region
// Optional macro DEADLOCK_MONITOR_STICKY_EN: block latches until reset once asserted.
module deadlock_idx0_monitor #(
   parameter int unsigned THRESHOLD = 1000,
   parameter int unsigned CNT_W     = 16
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [1:0] axis_block_sigs,
   input  logic [8:0] inst_idle_sigs,
   input  logic [4:0] inst_block_sigs,
   output logic       block
);

   localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(THRESHOLD);

   generate
      if (THRESHOLD < 1 || THRESHOLD > 65535 || (THRESHOLD >> CNT_W) != 0) begin : g_bad_param
         $error("deadlock_idx0_monitor: THRESHOLD out of range or does not fit in CNT_W");
      end
   endgenerate

   logic [4:0]       stalled;
   logic             blocked_any;
   logic             axis_any;
   logic             active;
   logic             cand;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_next;

   // An idle process that also raises block counts as idle only.
   always_comb begin
      stalled     = inst_idle_sigs[4:0] | inst_block_sigs;
      blocked_any = |(inst_block_sigs & ~inst_idle_sigs[4:0]);
      axis_any    = |axis_block_sigs;
      active      = ~&inst_idle_sigs;
      cand        = (&stalled) & blocked_any & ~axis_any & active;
   end

   always_comb begin
      cnt_next = '0;
      if (cand) begin
         if (cnt < THRESH_C) begin
            cnt_next = cnt + CNT_W'(1);
         end else begin
            cnt_next = THRESH_C;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         cnt   <= '0;
         block <= 1'b0;
      end else begin
         cnt <= cnt_next;
`ifdef DEADLOCK_MONITOR_STICKY_EN
         block <= block | (cnt_next == THRESH_C);
`else
         block <= (cnt_next == THRESH_C);
`endif
      end
   end

endmodule

// File: tb/tb_deadlock_idx0_monitor.sv
// tb/tb_deadlock_idx0_monitor.sv - self-checking bench for deadlock_idx0_monitor
// Directed vector table plus randomized run against a run-length reference model.
module tb_deadlock_idx0_monitor;

   localparam int TH = 4;
   localparam logic [8:0] IDLE_C = 9'b1_1101_1011;
   localparam logic [4:0] BLK_C  = 5'b00100;

   typedef struct {
      logic       rst;
      logic [1:0] axis;
      logic [8:0] idle;
      logic [4:0] blk;
      logic       exp;
   } vec_t;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [1:0] axis_block_sigs = '0;
   logic [8:0] inst_idle_sigs = '0;
   logic [4:0] inst_block_sigs = '0;
   logic       block;

   int checks = 0;
   int errors = 0;
   vec_t vecs[$];

   always #5 clock = ~clock;

   deadlock_idx0_monitor #(.THRESHOLD(TH), .CNT_W(16)) dut (
      .clock(clock),
      .reset(reset),
      .axis_block_sigs(axis_block_sigs),
      .inst_idle_sigs(inst_idle_sigs),
      .inst_block_sigs(inst_block_sigs),
      .block(block)
   );

   function automatic vec_t mk(logic r, logic [1:0] a, logic [8:0] i, logic [4:0] b, logic e);
      vec_t v;
      v.rst = r; v.axis = a; v.idle = i; v.blk = b; v.exp = e;
      return v;
   endfunction

   task automatic cand_rows(int n, logic e_last);
      for (int k = 0; k < n; k++)
         vecs.push_back(mk(1'b0, 2'b00, IDLE_C, BLK_C, (k == n - 1) ? e_last : 1'b0));
   endtask

   task automatic drop_row();
      vecs.push_back(mk(1'b0, 2'b00, IDLE_C, 5'b00000, 1'b0));
   endtask

   task automatic check(string name, logic act, logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: block=%b expected=%b at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic apply(logic r, logic [1:0] a, logic [8:0] i, logic [4:0] b);
      reset = r; axis_block_sigs = a; inst_idle_sigs = i; inst_block_sigs = b;
      @(posedge clock);
      @(negedge clock);
   endtask

   // Reference: length of the current run of deadlock-candidate cycles.
   function automatic logic ref_cand(logic [1:0] a, logic [8:0] i, logic [4:0] b);
      logic all_stalled = 1'b1;
      logic any_blocked = 1'b0;
      for (int p = 0; p < 5; p++) begin
         if (!(i[p] || b[p])) all_stalled = 1'b0;
         if (b[p] && !i[p]) any_blocked = 1'b1;
      end
      return all_stalled && any_blocked && (a == 2'b00) && (i != 9'h1FF);
   endfunction

   initial begin
      int run;
      logic seen;
      logic exp;
      logic [1:0] a;
      logic [8:0] i;
      logic [4:0] b;
      logic r;

      // reset state
      vecs.push_back(mk(1'b1, 2'b00, IDLE_C, BLK_C, 1'b0));
      // basic assert after THRESHOLD edges, saturation, fall after drop
      cand_rows(TH, 1'b1);
      vecs.push_back(mk(1'b0, 2'b00, IDLE_C, BLK_C, 1'b1));
      drop_row();
      // stall on environment clears count
      cand_rows(1, 1'b0);
      vecs.push_back(mk(1'b0, 2'b01, IDLE_C, BLK_C, 1'b0));
      cand_rows(TH, 1'b1);
      vecs.push_back(mk(1'b0, 2'b10, IDLE_C, BLK_C, 1'b0));
      // single-cycle drop restarts the count
      cand_rows(3, 1'b0);
      drop_row();
      cand_rows(TH, 1'b1);
      drop_row();
      // reset mid-count and while block is held
      cand_rows(2, 1'b0);
      vecs.push_back(mk(1'b1, 2'b00, IDLE_C, BLK_C, 1'b0));
      cand_rows(TH, 1'b1);
      vecs.push_back(mk(1'b1, 2'b00, IDLE_C, BLK_C, 1'b0));
      cand_rows(TH, 1'b1);
      vecs.push_back(mk(1'b1, 2'b00, IDLE_C, BLK_C, 1'b0));

      @(negedge clock);
      foreach (vecs[n]) begin
         apply(vecs[n].rst, vecs[n].axis, vecs[n].idle, vecs[n].blk);
`ifdef DEADLOCK_MONITOR_STICKY_EN
         if (!vecs[n].rst && block === 1'b1) continue;
`endif
         check($sformatf("vec%0d", n), block, vecs[n].exp);
      end

      // all processes idle and flagging block is never a deadlock
      for (int k = 0; k < 100; k++) begin
         apply(1'b0, 2'b00, 9'b0_0001_1111, 5'h1F);
         if (k % 10 == 9) check("all_idle", block, 1'b0);
      end

      // sticky-vs-follow behaviour on cand drop
      apply(1'b1, 2'b00, IDLE_C, BLK_C);
      for (int k = 0; k < TH; k++) apply(1'b0, 2'b00, IDLE_C, BLK_C);
      check("held_high", block, 1'b1);
      drop_row_apply: begin
         apply(1'b0, 2'b00, IDLE_C, 5'b00000);
`ifdef DEADLOCK_MONITOR_STICKY_EN
         check("sticky_hold", block, 1'b1);
`else
         check("drop_fall", block, 1'b0);
`endif
      end

      // randomized run against the reference model
      apply(1'b1, 2'b00, IDLE_C, BLK_C);
      run = 0;
      seen = 1'b0;
      for (int k = 0; k < 3000; k++) begin
         r = ($urandom_range(0, 63) == 0);
         a = ($urandom_range(0, 15) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         if ($urandom_range(0, 7) != 0) begin
            i = IDLE_C;
            b = BLK_C;
            if ($urandom_range(0, 3) == 0) begin
               int p = $urandom_range(0, 4);
               i[p] = $urandom_range(0, 1);
               b[p] = $urandom_range(0, 1);
            end
            if ($urandom_range(0, 15) == 0) i[8:5] = 4'($urandom);
         end else begin
            i = 9'($urandom);
            b = 5'($urandom);
         end
         apply(r, a, i, b);
         if (r) begin
            run = 0;
            seen = 1'b0;
         end else if (ref_cand(a, i, b)) begin
            run++;
         end else begin
            run = 0;
         end
         if (run >= TH) seen = 1'b1;
`ifdef DEADLOCK_MONITOR_STICKY_EN
         exp = seen;
`else
         exp = (run >= TH);
`endif
         check($sformatf("rand%0d", k), block, exp);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
